// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle: fetch requester, load/store requester
// and the synchronous memory, as seen from the arbiter (slave side).
interface mem_port_arbiter_if #(
  parameter int ADDR_LEN = 16,
  parameter int DATA_W   = 16
);
  logic                fetch_req;
  logic [ADDR_LEN-1:0] fetch_addr;
  logic                fetch_ack;
  logic [DATA_W-1:0]   fetch_rdata;
  logic                ls_req;
  logic                ls_write;
  logic [ADDR_LEN-1:0] ls_addr;
  logic [DATA_W-1:0]   ls_wdata;
  logic                ls_ack;
  logic [DATA_W-1:0]   ls_rdata;
  logic [ADDR_LEN-1:0] mem_addr;
  logic                mem_enable;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                busy;
  logic                grant_ls;

  modport slave (
    input  fetch_req, fetch_addr,
    input  ls_req, ls_write, ls_addr, ls_wdata,
    input  mem_rdata,
    output fetch_ack, fetch_rdata,
    output ls_ack, ls_rdata,
    output mem_addr, mem_enable, mem_write, mem_wdata,
    output busy, grant_ls
  );

  modport master (
    output fetch_req, fetch_addr,
    output ls_req, ls_write, ls_addr, ls_wdata,
    output mem_rdata,
    input  fetch_ack, fetch_rdata,
    input  ls_ack, ls_rdata,
    input  mem_addr, mem_enable, mem_write, mem_wdata,
    input  busy, grant_ls
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between
// instruction fetch and load/store; one access in flight, all outputs registered.
module mem_port_arbiter #(
  parameter int ADDR_LEN = 16,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                last_ls_q, last_ls_d;
  logic                own_ls_q, own_ls_d;
  logic                wr_q, wr_d;
  logic                fack_q, fack_d;
  logic                lack_q, lack_d;
  logic [DATA_W-1:0]   frd_q, frd_d;
  logic [DATA_W-1:0]   lrd_q, lrd_d;
  logic [ADDR_LEN-1:0] maddr_q, maddr_d;
  logic                men_q, men_d;
  logic                mwr_q, mwr_d;
  logic [DATA_W-1:0]   mwd_q, mwd_d;
  logic                busy_q, busy_d;
  logic                pick_ls;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_ls_d = last_ls_q;
    own_ls_d  = own_ls_q;
    wr_d      = wr_q;
    frd_d     = frd_q;
    lrd_d     = lrd_q;
    fack_d    = 1'b0;
    lack_d    = 1'b0;
    maddr_d   = '0;
    men_d     = 1'b0;
    mwr_d     = 1'b0;
    mwd_d     = '0;
    pick_ls   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.fetch_req || bus.ls_req) begin
          // On a tie, serve whoever did not own the previous access
          pick_ls   = bus.ls_req &&
                      (!bus.fetch_req || !last_ls_q);
          own_ls_d  = pick_ls;
          last_ls_d = pick_ls;
          wr_d      = pick_ls && bus.ls_write;
          state_d   = ACCESS;
          men_d     = 1'b1;
          mwr_d     = wr_d;
          maddr_d   = pick_ls ? bus.ls_addr : bus.fetch_addr;
          mwd_d     = pick_ls ? bus.ls_wdata : '0;
        end
      end
      ACCESS: begin
        if (wr_q) begin
          state_d = DONE;
          fack_d  = !own_ls_q;
          lack_d  = own_ls_q;
        end else begin
          state_d = WAIT;
          cnt_d   = CW'(READ_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          fack_d  = !own_ls_q;
          lack_d  = own_ls_q;
          if (own_ls_q) lrd_d = bus.mem_rdata;
          else          frd_d = bus.mem_rdata;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_ls_q <= 1'b1;
      own_ls_q  <= 1'b0;
      wr_q      <= 1'b0;
      fack_q    <= 1'b0;
      lack_q    <= 1'b0;
      frd_q     <= '0;
      lrd_q     <= '0;
      maddr_q   <= '0;
      men_q     <= 1'b0;
      mwr_q     <= 1'b0;
      mwd_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_ls_q <= last_ls_d;
      own_ls_q  <= own_ls_d;
      wr_q      <= wr_d;
      fack_q    <= fack_d;
      lack_q    <= lack_d;
      frd_q     <= frd_d;
      lrd_q     <= lrd_d;
      maddr_q   <= maddr_d;
      men_q     <= men_d;
      mwr_q     <= mwr_d;
      mwd_q     <= mwd_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.fetch_ack   = fack_q;
  assign bus.fetch_rdata = frd_q;
  assign bus.ls_ack      = lack_q;
  assign bus.ls_rdata    = lrd_q;
  assign bus.mem_addr    = maddr_q;
  assign bus.mem_enable  = men_q;
  assign bus.mem_write   = mwr_q;
  assign bus.mem_wdata   = mwd_q;
  assign bus.busy        = busy_q;
  assign bus.grant_ls    = own_ls_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle vector table for
// READ_LAT=1 plus hand sequences for reset, req drop and READ_LAT=3.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_LEN(16), .DATA_W(16)) if1 ();
  mem_port_arbiter_if #(.ADDR_LEN(16), .DATA_W(16)) if3 ();

  mem_port_arbiter #(.ADDR_LEN(16), .DATA_W(16), .READ_LAT(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  mem_port_arbiter #(.ADDR_LEN(16), .DATA_W(16), .READ_LAT(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3.slave)
  );

  typedef struct {
    logic        fr;
    logic [15:0] fa;
    logic        lr;
    logic        lw;
    logic [15:0] la;
    logic [15:0] lwd;
    logic [15:0] md;
    logic        fack;
    logic [15:0] frd;
    logic        lack;
    logic [15:0] lrd;
    logic [15:0] ma;
    logic        en;
    logic        wr;
    logic [15:0] mwd;
    logic        busy;
    logic        gl;
  } vec_t;

  vec_t tv [26];

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [69:0] pk_exp(input vec_t v);
    return {v.fack, v.frd, v.lack, v.lrd, v.ma,
            v.en, v.wr, v.mwd, v.busy, v.gl};
  endfunction

  function automatic logic [69:0] pk_if1();
    return {if1.fetch_ack, if1.fetch_rdata, if1.ls_ack,
            if1.ls_rdata, if1.mem_addr, if1.mem_enable,
            if1.mem_write, if1.mem_wdata, if1.busy,
            if1.grant_ls};
  endfunction

  function automatic logic [69:0] pk_if3();
    return {if3.fetch_ack, if3.fetch_rdata, if3.ls_ack,
            if3.ls_rdata, if3.mem_addr, if3.mem_enable,
            if3.mem_write, if3.mem_wdata, if3.busy,
            if3.grant_ls};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // fr fa lr lw la lwd md | fack frd lack lrd ma en wr mwd busy gl
    tv[0]  = '{1,16'h0020,1,0,16'h0030,16'h0,16'h0000,
               0,16'h0000,0,16'h0000,16'h0020,1,0,16'h0,1,0};
    tv[1]  = '{1,16'h0020,1,0,16'h0030,16'h0,16'h0000,
               0,16'h0000,0,16'h0000,16'h0000,0,0,16'h0,1,0};
    tv[2]  = '{1,16'h0020,1,0,16'h0030,16'h0,16'h1111,
               1,16'h1111,0,16'h0000,16'h0000,0,0,16'h0,1,0};
    tv[3]  = '{1,16'h0020,1,0,16'h0030,16'h0,16'h0000,
               0,16'h1111,0,16'h0000,16'h0000,0,0,16'h0,0,0};
    tv[4]  = '{1,16'h0020,1,0,16'h0030,16'h0,16'h0000,
               0,16'h1111,0,16'h0000,16'h0030,1,0,16'h0,1,1};
    tv[5]  = '{1,16'h0020,1,0,16'h0030,16'h0,16'h0000,
               0,16'h1111,0,16'h0000,16'h0000,0,0,16'h0,1,1};
    tv[6]  = '{1,16'h0020,1,0,16'h0030,16'h0,16'h2222,
               0,16'h1111,1,16'h2222,16'h0000,0,0,16'h0,1,1};
    tv[7]  = '{1,16'h0020,1,0,16'h0030,16'h0,16'h0000,
               0,16'h1111,0,16'h2222,16'h0000,0,0,16'h0,0,1};
    tv[8]  = '{1,16'h0020,1,0,16'h0030,16'h0,16'h0000,
               0,16'h1111,0,16'h2222,16'h0020,1,0,16'h0,1,0};
    tv[9]  = '{1,16'h0020,1,0,16'h0030,16'h0,16'h0000,
               0,16'h1111,0,16'h2222,16'h0000,0,0,16'h0,1,0};
    tv[10] = '{1,16'h0020,1,0,16'h0030,16'h0,16'h3333,
               1,16'h3333,0,16'h2222,16'h0000,0,0,16'h0,1,0};
    tv[11] = '{1,16'h0020,1,0,16'h0030,16'h0,16'h0000,
               0,16'h3333,0,16'h2222,16'h0000,0,0,16'h0,0,0};
    tv[12] = '{1,16'h0020,1,0,16'h0030,16'h0,16'h0000,
               0,16'h3333,0,16'h2222,16'h0030,1,0,16'h0,1,1};
    tv[13] = '{1,16'h0020,1,0,16'h0030,16'h0,16'h0000,
               0,16'h3333,0,16'h2222,16'h0000,0,0,16'h0,1,1};
    tv[14] = '{1,16'h0020,1,0,16'h0030,16'h0,16'h4444,
               0,16'h3333,1,16'h4444,16'h0000,0,0,16'h0,1,1};
    tv[15] = '{1,16'h0020,1,0,16'h0030,16'h0,16'h0000,
               0,16'h3333,0,16'h4444,16'h0000,0,0,16'h0,0,1};
    tv[16] = '{0,16'h0020,0,0,16'h0030,16'h0,16'h0000,
               0,16'h3333,0,16'h4444,16'h0000,0,0,16'h0,0,1};
    tv[17] = '{1,16'h0010,0,0,16'h0000,16'h0,16'hDEAD,
               0,16'h3333,0,16'h4444,16'h0010,1,0,16'h0,1,0};
    tv[18] = '{1,16'h0010,0,0,16'h0000,16'h0,16'hDEAD,
               0,16'h3333,0,16'h4444,16'h0000,0,0,16'h0,1,0};
    tv[19] = '{1,16'h0010,0,0,16'h0000,16'h0,16'h0105,
               1,16'h0105,0,16'h4444,16'h0000,0,0,16'h0,1,0};
    tv[20] = '{1,16'h0010,0,0,16'h0000,16'h0,16'hDEAD,
               0,16'h0105,0,16'h4444,16'h0000,0,0,16'h0,0,0};
    tv[21] = '{0,16'h0010,0,0,16'h0000,16'h0,16'hDEAD,
               0,16'h0105,0,16'h4444,16'h0000,0,0,16'h0,0,0};
    tv[22] = '{0,16'h0000,1,1,16'hFFFF,16'hBEEF,16'h0000,
               0,16'h0105,0,16'h4444,16'hFFFF,1,1,16'hBEEF,1,1};
    tv[23] = '{0,16'h0000,1,1,16'h1234,16'h0000,16'h0000,
               0,16'h0105,1,16'h4444,16'h0000,0,0,16'h0,1,1};
    tv[24] = '{0,16'h0000,1,1,16'h1234,16'h0000,16'h0000,
               0,16'h0105,0,16'h4444,16'h0000,0,0,16'h0,0,1};
    tv[25] = '{0,16'h0000,0,0,16'h0000,16'h0000,16'h0000,
               0,16'h0105,0,16'h4444,16'h0000,0,0,16'h0,0,1};

    if1.fetch_req  = 0; if1.fetch_addr = '0;
    if1.ls_req     = 0; if1.ls_write   = 0;
    if1.ls_addr    = '0; if1.ls_wdata  = '0;
    if1.mem_rdata  = '0;
    if3.fetch_req  = 0; if3.fetch_addr = '0;
    if3.ls_req     = 0; if3.ls_write   = 0;
    if3.ls_addr    = '0; if3.ls_wdata  = '0;
    if3.mem_rdata  = '0;

    cyc();
    cyc();
    chk("reset_dut1", 128'(pk_if1()), 128'(0));
    chk("reset_dut3", 128'(pk_if3()), 128'(0));
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      if1.fetch_req  = tv[i].fr;
      if1.fetch_addr = tv[i].fa;
      if1.ls_req     = tv[i].lr;
      if1.ls_write   = tv[i].lw;
      if1.ls_addr    = tv[i].la;
      if1.ls_wdata   = tv[i].lwd;
      if1.mem_rdata  = tv[i].md;
      cyc();
      chk($sformatf("vec%0d", i), 128'(pk_if1()),
          128'(pk_exp(tv[i])));
    end

    // fetch request withdrawn right after grant
    if1.fetch_req  = 1;
    if1.fetch_addr = 16'h0040;
    if1.mem_rdata  = 16'h0000;
    cyc();
    chk("drop_grant", {if1.mem_enable, if1.mem_addr,
        if1.grant_ls}, {1'b1, 16'h0040, 1'b0});
    if1.fetch_req = 0;
    cyc();
    chk("drop_wait", {if1.busy, if1.mem_enable},
        {1'b1, 1'b0});
    if1.mem_rdata = 16'h6666;
    cyc();
    chk("drop_ack", {if1.fetch_ack, if1.fetch_rdata},
        {1'b1, 16'h6666});
    if1.mem_rdata = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("drop_idle%0d", k),
          {if1.fetch_ack, if1.mem_enable, if1.busy}, 3'b000);
    end

    // reset asserted in the WAIT state of a fetch read
    if1.fetch_req  = 1;
    if1.fetch_addr = 16'h0050;
    cyc();
    cyc();
    chk("rst_pre_wait", {if1.busy, if1.mem_enable},
        {1'b1, 1'b0});
    #2 rst = 1'b1;
    #1;
    chk("rst_async", 128'(pk_if1()), 128'(0));
    cyc();
    rst = 1'b0;
    if1.fetch_req = 0;
    if1.mem_rdata = 16'h7777;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("rst_after%0d", k),
          {if1.fetch_ack, if1.mem_enable, if1.busy,
           if1.fetch_rdata}, {3'b000, 16'h0000});
    end

    // READ_LAT=3 load: word present only on final WAIT cycle
    if3.ls_req   = 1;
    if3.ls_write = 0;
    if3.ls_addr  = 16'h0200;
    for (int k = 1; k <= 7; k++) begin
      if3.mem_rdata = (k == 5) ? 16'h5A5A : 16'hAAAA;
      cyc();
      if (k == 1)
        chk("lat3_access", {if3.mem_enable, if3.mem_write,
            if3.mem_addr, if3.grant_ls},
            {1'b1, 1'b0, 16'h0200, 1'b1});
      chk($sformatf("lat3_ack_t%0d", k),
          {if3.ls_ack, if3.fetch_ack}, {(k == 5), 1'b0});
      if (k == 5) begin
        chk("lat3_rdata", 128'(if3.ls_rdata), 128'(16'h5A5A));
        if3.ls_req = 0;
      end
    end
    chk("lat3_hold", {if3.ls_rdata, if3.busy},
        {16'h5A5A, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
